// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial link.
// Contents:
//   DAC_DATA_W     - width of a DAC code
//   DAC_FRAME_BITS - serial bits per frame: code bits, then zero fill bits
//   SPI_DIV        - s_clk cycles per spi_clk period on the link
//   ST_*           - receiver FSM state encoding
package dac_pkg;

  localparam int DAC_DATA_W     = 10;
  localparam int DAC_FRAME_BITS = 12;
  localparam int SPI_DIV        = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/dac_spi_rx_sync_edge.sv
// sync_edge: multi-flop synchroniser with edge detection.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   din      - asynchronous input
//   level    - synchronised level (last flop of the chain)
//   rise     - one-cycle pulse on a synchronised 0->1 transition
//   fall     - one-cycle pulse on a synchronised 1->0 transition
// All flops reset to RESET_VAL, which should be the idle level of din.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~prev;
  assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: oversampling SPI slave receiver for the 3-wire DAC link.
// Ports:
//   s_clk, s_rst         - system clock, asynchronous active-high reset
//   spi_clk, mosi,
//   spi_cs_n             - asynchronous serial link from the master
//   data_out             - code of the last good frame (held)
//   data_valid           - one-cycle pulse when data_out updates
//   frame_err            - one-cycle pulse on a malformed frame
//   busy                 - high while receiving (RECV)
//   frame_cnt            - good frame count, wraps
//   state                - FSM state (ST_* encoding), for observation
//
// Handshake: data_valid and frame_err are single-cycle strobes with no
// back-pressure; data_out is stable from the data_valid cycle onwards
// until the next data_valid.
module dac_spi_rx
  import dac_pkg::*;
#(
  parameter int DATA_W      = DAC_DATA_W,
  parameter int FRAME_BITS  = DAC_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              spi_clk,
  input  logic              mosi,
  input  logic              spi_cs_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        state
);

  localparam int FILL_W = FRAME_BITS - DATA_W;
  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(s_clk), .rst(s_rst), .din(spi_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(s_clk), .rst(s_rst), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(s_clk), .rst(s_rst), .din(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // The cs synchroniser resets to 1, so if spi_cs_n is held low through
  // reset a false fall appears once the chain flushes. Frames are only
  // accepted after cs has been seen high with the chain fully refilled.
  logic [SYNC_STAGES:0] flush;
  logic                 armed;
  logic                 pend;
  logic                 cs_fall_ok;

  assign cs_fall_ok = cs_fall & armed;

  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
  logic                  good;

  // Next shift/count values: lets a bit arriving in the cs_rise cycle be
  // counted before the frame is judged.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (sclk_rise) begin
      shreg_nxt = {shreg[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + CNT_W'(1);
    end
    good = (cnt_nxt == CNT_GOOD) && (shreg_nxt[FILL_W-1:0] == '0);
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      flush      <= '0;
      armed      <= 1'b0;
      pend       <= 1'b0;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
      armed      <= armed | (flush[SYNC_STAGES] & cs_level);
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall_ok || pend) begin
            pend    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= ST_RECV;
          end
        end
        ST_RECV: begin
          bit_cnt <= cnt_nxt;
          shreg   <= shreg_nxt;
          // The verdict is registered on the cs_rise edge so the strobe
          // and the new data_out appear together during CHECK.
          if (cs_rise) begin
            state <= ST_CHECK;
            if (good) begin
              data_out   <= shreg_nxt[FRAME_BITS-1 -: DATA_W];
              data_valid <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (cs_fall_ok) pend <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RECV);

endmodule
